// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus arbiter slice: state encoding, default
// watchdog length and the address of the on-board BH1750 light sensor.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    XFER    = 2'd2,
    HOLDOFF = 2'd3
  } arb_state_e;

  // About 200 ms at 12 MHz
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 2_400_000;

  localparam logic [6:0] BH1750_ADDR = 7'h23;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: one-hot of the first set request bit at or
// above i_ptr, wrapping around to bit 0.
module rr_priority_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick
);

  // Distance from the pointer decides priority; the smallest distance wins.
  always_comb begin
    int bestOff;
    int off;
    bestOff = N_REQ;
    off     = 0;
    o_pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      off = (i + N_REQ - int'(i_ptr)) % N_REQ;
      if (i_req[i] && (off < bestOff)) begin
        bestOff   = off;
        o_pick    = '0;
        o_pick[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one i2c_master between N_REQ sensor sequencers with round-robin
// fairness, owner-only routing of done/reg_ready and a per-transfer watchdog.
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     r_start,
  input  logic [7*N_REQ-1:0]   r_addr,
  input  logic [N_REQ-1:0]     r_rw,
  input  logic [8*N_REQ-1:0]   r_data,
  input  logic [N_REQ-1:0]     r_ack,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     r_done,
  output logic [N_REQ-1:0]     r_reg_ready,
  output logic [7:0]           r_data_slave,
  output logic [N_REQ-1:0]     timeout_err,
  input  logic                 err_clr,
  output logic                 bus_timeout,
  output logic                 m_start,
  output logic [6:0]           m_slave_addr,
  output logic                 m_rw,
  output logic [7:0]           m_data_in,
  output logic                 m_ack_master,
  input  logic [7:0]           m_data_slave,
  input  logic                 m_done,
  input  logic                 m_reg_ready
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_rrPtr;
  logic [N_REQ-1:0] r_grant;
  logic [WD_W-1:0]  r_wdCnt;
  logic [GAP_W-1:0] r_gapCnt;
  logic [N_REQ-1:0] r_timeoutErr;
  logic             r_busTimeout;

  logic [N_REQ-1:0] w_pick;
  logic [IDX_W-1:0] w_ownerIdx;
  logic [IDX_W-1:0] w_nextPtr;
  logic             w_ownerReq;
  logic             w_ownerStart;
  logic             w_wdExpire;
  logic [N_REQ-1:0] w_errSet;

  rr_priority_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req  (req),
    .i_ptr  (r_rrPtr),
    .o_pick (w_pick)
  );

  // grant is one-hot or zero, so this loop is a plain mux that yields 0 when unowned
  always_comb begin
    w_ownerIdx   = '0;
    m_start      = 1'b0;
    m_slave_addr = '0;
    m_rw         = 1'b0;
    m_data_in    = '0;
    m_ack_master = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_ownerIdx   = IDX_W'(i);
        m_start      = r_start[i];
        m_slave_addr = r_addr[7*i +: 7];
        m_rw         = r_rw[i];
        m_data_in    = r_data[8*i +: 8];
        m_ack_master = r_ack[i];
      end
    end
  end

  assign w_ownerReq   = |(req & r_grant);
  assign w_ownerStart = |(r_start & r_grant);
  assign w_nextPtr    = (w_ownerIdx == IDX_W'(N_REQ - 1)) ? '0 : w_ownerIdx + 1'b1;
  assign w_wdExpire   = (r_state == XFER) && !m_done && !m_reg_ready &&
                        (r_wdCnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_errSet     = w_wdExpire ? r_grant : '0;

  assign grant        = r_grant;
  assign r_done       = r_grant & {N_REQ{m_done}};
  assign r_reg_ready  = r_grant & {N_REQ{m_reg_ready}};
  assign r_data_slave = m_data_slave;
  assign timeout_err  = r_timeoutErr;
  assign bus_timeout  = r_busTimeout;

  // HOLDOFF plus the IDLE arbitration cycle together keep grant low for GAP_CYCLES
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_rrPtr      <= '0;
      r_grant      <= '0;
      r_wdCnt      <= '0;
      r_gapCnt     <= '0;
      r_timeoutErr <= '0;
      r_busTimeout <= 1'b0;
    end else begin
      r_busTimeout <= 1'b0;
      r_timeoutErr <= (err_clr ? '0 : r_timeoutErr) | w_errSet;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_grant <= w_pick;
            r_state <= OWNED;
          end
        end
        OWNED: begin
          if (w_ownerStart) begin
            r_state <= XFER;
            r_wdCnt <= '0;
          end else if (!w_ownerReq) begin
            r_grant  <= '0;
            r_rrPtr  <= w_nextPtr;
            r_gapCnt <= GAP_W'(1);
            r_state  <= (GAP_CYCLES > 1) ? HOLDOFF : IDLE;
          end
        end
        XFER: begin
          if (m_done) begin
            r_state <= OWNED;
            r_wdCnt <= '0;
          end else if (m_reg_ready) begin
            r_wdCnt <= '0;
          end else if (w_wdExpire) begin
            r_busTimeout <= 1'b1;
            r_grant      <= '0;
            r_rrPtr      <= w_nextPtr;
            r_gapCnt     <= GAP_W'(1);
            r_state      <= (GAP_CYCLES > 1) ? HOLDOFF : IDLE;
          end else begin
            r_wdCnt <= r_wdCnt + 1'b1;
          end
        end
        HOLDOFF: begin
          if (r_gapCnt >= GAP_W'(GAP_CYCLES - 1)) begin
            r_state <= IDLE;
          end else begin
            r_gapCnt <= r_gapCnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
